dma_copy: RTL
=============

Name: dma_copy

Overview:
- Parametrised successor to the single-word copy engine: an Avalon-MM memory-to-memory copy DMA.
- CPU-facing slave exposes dst/src/length/control/status registers.
- SDRAM-facing master issues pipelined reads with multiple reads outstanding, buffers returned words in an internal FIFO, and drains the FIFO as writes.
- Sits between the CPU interconnect and the SDRAM controller. Adds byte addressing, configurable width/depth, status readback and a completion count.

Parameters:
- DATA_W, 32, master/slave data width in bits; multiple of 8.
- ADDR_W, 32, master address width.
- FIFO_DEPTH, 4, read-data buffer depth and maximum reads in flight; power of 2, at least 2.
- CNT_W, 32, word-count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- slave_waitrequest  out  1  slave stall
- slave_address  in  4  register select
- slave_read  in  1  register read
- slave_readdata  out  DATA_W  register read data
- slave_write  in  1  register write
- slave_writedata  in  DATA_W  register write data
- master_waitrequest  in  1  master stall
- master_address  out  ADDR_W  byte address
- master_read  out  1  read command
- master_readdata  in  DATA_W  read return data
- master_readdatavalid  in  1  read return strobe
- master_write  out  1  write command
- master_writedata  out  DATA_W  write data
- irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset: one clk edge with rst_n=0. All outputs 0; all registers 0; FSM to IDLE; FIFO and outstanding count emptied. Reset mid-transfer aborts immediately. readdatavalid arriving after reset for pre-reset reads is ignored: it is not pushed, and the outstanding count stays at 0.
- Register map, by slave_address:
  - 0 CTRL/STATUS. Write: start. Read: bit0 busy, bit1 done.
  - 1 DST.
  - 2 SRC.
  - 3 N, the word count.
  - 4 DONE_CNT, read-only: words written so far in the current or last transfer.
  - Unmapped addresses read 0; writes to them are ignored.
- Slave timing:
  - Reads are zero-wait; slave_readdata is combinational from the registers.
  - Writes while IDLE are zero-wait.
  - slave_waitrequest = slave_write and busy. A write during a transfer stalls until IDLE, then completes.
- FSM IDLE -> RUN on a CTRL write with N != 0.
  - On entry: done := 0; DONE_CNT := 0; rd_addr := SRC; wr_addr := DST; issued := 0.
  - CTRL write with N == 0: stay IDLE; done := 1; no bus activity.
- FSM RUN -> IDLE in the cycle the N-th write is accepted. On that transition done := 1 and busy := 0. busy is 1 exactly in RUN.
- Master bus rules:
  - At most one of master_read/master_write is high in any cycle.
  - An asserted command holds address, data and strobe unchanged until master_waitrequest=0 is sampled. It is accepted on that edge.
  - Command is chosen only when no command is pending.
  - Write has priority when the FIFO is non-empty: master_writedata = FIFO head; popped on acceptance; wr_addr and DONE_CNT advance.
  - Otherwise read when issued < N and (outstanding + fifo_count) < FIFO_DEPTH: master_address = rd_addr; on acceptance, issued and outstanding increment and rd_addr advances.
- readdatavalid: pushes master_readdata and decrements outstanding, in any cycle, including simultaneously with a pop or a read acceptance. The FIFO can never overflow because of the issue limit.
- Addresses advance by DATA_W/8 per word, modulo 2^ADDR_W; wrap-around is silent. Counts are modulo 2^CNT_W. N up to 2^CNT_W-1 is supported.
- Throughput: with zero-wait memory and fixed read latency L, the sustained rate approaches 1 word per 2 cycles once the pipeline fills.
- Register writes to DST/SRC/N while busy take effect only after the stall, so the running transfer is unaffected.

Optional Feature:
- Macro DMA_COPY_IRQ_EN.
- Defined:
  - irq is registered and set on the RUN->IDLE transition.
  - irq is also set on a zero-length start.
  - irq is cleared by a write to address 0 with bit1=1 (write-1-to-clear; bit0 of the same write still starts a transfer).
  - Status read bit2 = irq.
- Not defined: irq is constant 0, status bit2 reads 0, and any CTRL write starts a transfer regardless of data.

Test Plan:
- Write DST=0x100, SRC=0x40, N=4, CTRL; zero-wait memory with 2-cycle read latency.
  - Required: reads at 0x40, 0x44, 0x48, 0x4C.
  - Required: writes at 0x100..0x10C carry the source data in order.
  - Required: done=1, DONE_CNT=4, busy=0.
- N=0 then CTRL.
  - Required: no master_read/master_write ever asserted.
  - Required: status reads 0x2.
- Random master_waitrequest (50%) and read latency 1-6, N=37.
  - Required: strobes and addresses stable while stalled.
  - Required: outstanding + fifo never exceeds FIFO_DEPTH.
  - Required: all 37 words copied correctly.
- Slave write to SRC issued mid-transfer.
  - Required: slave_waitrequest high until IDLE.
  - Required: the current transfer is unaffected.
  - Required: SRC takes the new value afterwards.
- rst_n=0 for 1 cycle mid-transfer with 3 reads outstanding, then the 3 late readdatavalid pulses.
  - Required: all outputs 0 and FIFO empty.
  - Required: a following N=2 transfer copies correctly.
- SRC=0xFFFFFFFC, N=2.
  - Required: second read at 0x00000000.
  - Required (DMA_COPY_IRQ_EN): irq rises at completion and is cleared by CTRL write 0x2.

Source files
------------

// File: rtl/dma_copy.sv
// -----------------------------------------------------------------------------
// dma_copy: Avalon-MM memory-to-memory copy engine.
//
// The CPU programs DST, SRC and a word count N through the slave port, then
// writes CTRL to start. The master port issues pipelined reads from SRC and
// buffers the returned words in a small FIFO. It drains that FIFO as writes to
// DST. At most FIFO_DEPTH words are either in flight or buffered at any time,
// so the FIFO can never overflow.
//
// Parameters
//   DATA_W      master/slave data width (multiple of 8)
//   ADDR_W      master byte-address width
//   FIFO_DEPTH  read buffer depth = max reads in flight (power of 2, >= 2)
//   CNT_W       word-count width
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   slave_*                      CPU register port
//                                  0 CTRL/STATUS, 1 DST, 2 SRC, 3 N, 4 DONE_CNT
//   master_*                     SDRAM-side pipelined read / write port
//   irq                          completion interrupt
//
// Optional feature macro: DMA_COPY_IRQ_EN
//   defined   : registered irq, set on completion or on a zero-length start,
//               cleared by a CTRL write with bit1=1. Only a CTRL write with
//               bit0=1 starts a transfer. Status bit2 reads irq.
//   undefined : irq is tied to 0, status bit2 reads 0, and every CTRL write
//               starts a transfer.
//
// FSM states
//   state | meaning
//   IDLE  | no transfer; register writes complete without a stall
//   RUN   | copying; slave writes stall until the last write is accepted
// -----------------------------------------------------------------------------
module dma_copy #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [DATA_W-1:0] slave_readdata,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,

    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,

    output logic              irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [OCC_W-1:0]  DEPTH_C   = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] dst_reg, src_reg;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [CNT_W-1:0]  n_reg, issued, done_cnt;
    logic              done_reg;

    logic              cmd_rd, cmd_wr;
    logic              cmd_rd_nxt, cmd_wr_nxt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_rd_ptr, fifo_wr_ptr;
    logic [OCC_W-1:0]  fifo_cnt, outstanding;

    logic              busy;
    logic              reg_wr, ctrl_wr, start_req, run_start, zero_start;
    logic              rd_acc, wr_acc, push, slot_free, last_wr;
    logic [OCC_W-1:0]  fifo_cnt_nxt, outstanding_nxt;
    logic [CNT_W-1:0]  issued_nxt, done_cnt_nxt;
    logic              irq_bit;

    // ------------------------------------------------------------------
    // Slave side
    // ------------------------------------------------------------------
    assign busy              = (state == RUN);
    assign slave_waitrequest = slave_write & busy;
    assign reg_wr            = slave_write & ~busy;
    assign ctrl_wr           = reg_wr & (slave_address == 4'd0);

`ifdef DMA_COPY_IRQ_EN
    logic irq_reg;
    logic irq_clr;

    assign start_req = ctrl_wr & slave_writedata[0];
    assign irq_clr   = ctrl_wr & slave_writedata[1];
    assign irq_bit   = irq_reg;
`else
    assign start_req = ctrl_wr;
    assign irq_bit   = 1'b0;
`endif

    assign run_start  = start_req & (n_reg != '0);
    assign zero_start = start_req & (n_reg == '0);
    assign irq        = irq_bit;

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                4'd0: begin
                    slave_readdata[0] = busy;
                    slave_readdata[1] = done_reg;
                    slave_readdata[2] = irq_bit;
                end
                4'd1:    slave_readdata = DATA_W'(dst_reg);
                4'd2:    slave_readdata = DATA_W'(src_reg);
                4'd3:    slave_readdata = DATA_W'(n_reg);
                4'd4:    slave_readdata = DATA_W'(done_cnt);
                default: slave_readdata = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Master datapath bookkeeping
    // ------------------------------------------------------------------
    // Return strobes with nothing outstanding belong to reads that a reset
    // aborted, so they are dropped.
    always_comb begin
        rd_acc          = cmd_rd & ~master_waitrequest;
        wr_acc          = cmd_wr & ~master_waitrequest;
        push            = master_readdatavalid & (outstanding != '0);
        fifo_cnt_nxt    = fifo_cnt + OCC_W'(push) - OCC_W'(wr_acc);
        outstanding_nxt = outstanding + OCC_W'(rd_acc) - OCC_W'(push);
        issued_nxt      = issued + CNT_W'(rd_acc);
        done_cnt_nxt    = done_cnt + CNT_W'(wr_acc);
        last_wr         = wr_acc & (done_cnt_nxt == n_reg);
        // A new command may be chosen on the same edge the pending one is
        // accepted; this keeps the bus busy every cycle once the pipe fills.
        slot_free       = ~(cmd_rd | cmd_wr) | rd_acc | wr_acc;
    end

    // The command and its side effects are decided on post-edge counts, so
    // the issue limit (in flight + buffered <= depth) holds at every edge.
    always_comb begin
        state_nxt  = state;
        cmd_rd_nxt = cmd_rd;
        cmd_wr_nxt = cmd_wr;
        case (state)
            IDLE: begin
                cmd_rd_nxt = 1'b0;
                cmd_wr_nxt = 1'b0;
                if (run_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_wr) begin
                    state_nxt  = IDLE;
                    cmd_rd_nxt = 1'b0;
                    cmd_wr_nxt = 1'b0;
                end else if (slot_free) begin
                    cmd_rd_nxt = 1'b0;
                    cmd_wr_nxt = 1'b0;
                    if (fifo_cnt_nxt != '0) begin
                        cmd_wr_nxt = 1'b1;
                    end else if ((issued_nxt < n_reg) &&
                                 ((outstanding_nxt + fifo_cnt_nxt) < DEPTH_C)) begin
                        cmd_rd_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                cmd_rd_nxt = 1'b0;
                cmd_wr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_rd      <= 1'b0;
            cmd_wr      <= 1'b0;
            dst_reg     <= '0;
            src_reg     <= '0;
            n_reg       <= '0;
            rd_addr     <= '0;
            wr_addr     <= '0;
            issued      <= '0;
            done_cnt    <= '0;
            done_reg    <= 1'b0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            fifo_rd_ptr <= '0;
            fifo_wr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            cmd_rd <= cmd_rd_nxt;
            cmd_wr <= cmd_wr_nxt;

            if (reg_wr) begin
                case (slave_address)
                    4'd1:    dst_reg <= ADDR_W'(slave_writedata);
                    4'd2:    src_reg <= ADDR_W'(slave_writedata);
                    4'd3:    n_reg   <= CNT_W'(slave_writedata);
                    default: ;
                endcase
            end

            if (run_start) begin
                done_reg <= 1'b0;
                done_cnt <= '0;
                rd_addr  <= src_reg;
                wr_addr  <= dst_reg;
                issued   <= '0;
            end else begin
                if (zero_start || last_wr) begin
                    done_reg <= 1'b1;
                end
                if (rd_acc) begin
                    rd_addr <= rd_addr + ADDR_STEP;
                end
                if (wr_acc) begin
                    wr_addr <= wr_addr + ADDR_STEP;
                end
                issued   <= issued_nxt;
                done_cnt <= done_cnt_nxt;
            end

            fifo_cnt    <= fifo_cnt_nxt;
            outstanding <= outstanding_nxt;
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
            end
            if (wr_acc) begin
                fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: its contents are only visible through the head
    // while a write is pending, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= master_readdata;
        end
    end

`ifdef DMA_COPY_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else if (zero_start || last_wr) begin
            irq_reg <= 1'b1;
        end else if (irq_clr) begin
            irq_reg <= 1'b0;
        end
    end
`endif

    // Address and data come from live state; neither changes while the
    // command is stalled because both advance only on acceptance.
    assign master_read      = cmd_rd;
    assign master_write     = cmd_wr;
    assign master_address   = cmd_wr ? wr_addr : (cmd_rd ? rd_addr : '0);
    assign master_writedata = cmd_wr ? fifo_mem[fifo_rd_ptr] : '0;

endmodule
